// File: rtl/nts_api_initiator_pkg.sv
// Shared types and constants for the NTS API initiator.
package nts_api_initiator_pkg;

  localparam int API_ADDR_W = 12;
  localparam int API_DATA_W = 32;
  localparam int TCNT_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [API_ADDR_W-1:0] addr;
    logic [API_DATA_W-1:0] wdata;
  } cmd_t;

  // Saturating increment for the timeout counter.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + {{(TCNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nts_api_initiator.sv
// Single-outstanding command initiator for the NTS API slave: issues a one-cycle
// cs pulse, waits for read_data_valid with a timeout, and returns a response.
module nts_api_initiator
  import nts_api_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [API_ADDR_W-1:0] i_cmd_address,
  input  logic [API_DATA_W-1:0] i_cmd_write_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [API_DATA_W-1:0] o_rsp_read_data,
  output logic                  o_rsp_error,
  output logic                  o_api_cs,
  output logic                  o_api_we,
  output logic [API_ADDR_W-1:0] o_api_address,
  output logic [API_DATA_W-1:0] o_api_write_data,
  input  logic [API_DATA_W-1:0] i_api_read_data,
  input  logic                  i_api_read_data_valid,
  input  logic                  i_api_busy,
  output logic [TCNT_W-1:0]     o_timeout_count
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);

  state_t                r_state;
  cmd_t                  r_cmd;
  logic                  r_cmd_ready;
  logic                  r_cs;
  logic [7:0]            r_timer;
  logic                  r_rsp_valid;
  logic [API_DATA_W-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [TCNT_W-1:0]     r_tcount;

  // Transaction FSM; all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_cmd_ready <= 1'b1;
      r_cs        <= 1'b0;
      r_timer     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_tcount    <= '0;
    end else begin
      r_cs <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_cmd       <= '{we: i_cmd_we, addr: i_cmd_address, wdata: i_cmd_write_data};
            r_cmd_ready <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Hold off the cs pulse while the slave reports busy.
          if (!i_api_busy) begin
            r_cs    <= 1'b1;
            r_timer <= TMO_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer - 8'd1;
          // A valid in the final WAIT cycle still wins over expiry.
          if (i_api_read_data_valid) begin
            r_rsp_data  <= r_cmd.we ? '0 : i_api_read_data;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_timer == 8'd1) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_tcount    <= sat_inc(r_tcount);
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready      = r_cmd_ready;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_read_data  = r_rsp_data;
  assign o_rsp_error      = r_rsp_err;
  assign o_api_cs         = r_cs;
  assign o_api_we         = r_cmd.we;
  assign o_api_address    = r_cmd.addr;
  assign o_api_write_data = r_cmd.wdata;
  assign o_timeout_count  = r_tcount;

endmodule

// File: doc/nts_api_initiator.md
NTS_API_INITIATOR -- requirements
Module: nts_api_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, cycles after the cs pulse within which read_data_valid must arrive; legal range 5..255.
REQ-002 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 i_areset_n  input  1  reset, asynchronous and active-low.
REQ-004 i_cmd_valid  input  1  command request.
REQ-005 o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
REQ-006 i_cmd_we  input  1  1 = write, 0 = read.
REQ-007 i_cmd_address  input  12  external API word address.
REQ-008 i_cmd_write_data  input  32  write payload.
REQ-009 o_rsp_valid  output  1  response available.
REQ-010 i_rsp_ready  input  1  response consumed when high together with o_rsp_valid.
REQ-011 o_rsp_read_data  output  32  read result; 0 for writes and on timeout.
REQ-012 o_rsp_error  output  1  transaction timed out.
REQ-013 o_api_cs, o_api_we  output  1 each  drive the API slave's external cs/we.
REQ-014 o_api_address  output  12; o_api_write_data  output  32  drive the API slave's external address and write data.
REQ-015 i_api_read_data  input  32; i_api_read_data_valid  input  1; i_api_busy  input  1  from the API slave.
REQ-016 o_timeout_count  output  16  saturating count of timed-out transactions.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-018 IDLE: o_cmd_ready=1; on i_cmd_valid&o_cmd_ready, register we/address/write_data and go to ISSUE.
REQ-019 o_cmd_ready is 0 in every state other than IDLE.
REQ-020 ISSUE: if i_api_busy=1, stay with o_api_cs=0; otherwise go to WAIT, assert registered o_api_cs for exactly one cycle and load the timer with TIMEOUT_CYCLES.
REQ-021 o_api_we/address/write_data hold the registered command from ISSUE until the next accepted command.
REQ-022 WAIT: the timer decrements by 1 each cycle.
REQ-023 WAIT, i_api_read_data_valid=1: capture i_api_read_data (force 0 if the command was a write), set error=0 and go to RESP; valid takes priority over expiry in the same cycle.
REQ-024 WAIT, timer reaches 0 with no valid: set data=0 and error=1, increment o_timeout_count (saturating at 16'hFFFF) and go to RESP.
REQ-025 RESP: o_rsp_valid=1 with stable data/error; on i_rsp_ready go to IDLE; no back-to-back overlap.
REQ-026 i_api_read_data_valid outside WAIT is ignored and changes no state.
REQ-027 Latency with idle slave: cmd handshake at edge E; o_api_cs high in the cycle after E; slave valid 4 cycles after the cs cycle; o_rsp_valid high 6 cycles after E.

Reset
REQ-028 Asserting i_areset_n low immediately forces IDLE; all outputs go to 0 except o_cmd_ready, which goes to 1 once in IDLE; o_timeout_count clears; all command/data registers clear.
REQ-029 Reset mid-transaction drops the transaction silently; a late slave valid after reset release is ignored per REQ-026.

Structure
REQ-030 FSM state encodings and the API address/data widths (12/32) live in the shared nts package.
REQ-031 The block is a single module; no sub-module is required.

Verification
REQ-032 Read 12'h011, slave returns 32'hDEADBEEF at cs+4 -> o_rsp_valid 6 cycles after the handshake, data=32'hDEADBEEF, error=0.
REQ-033 Write 12'h205 with data 32'h12345678 -> o_api_cs pulse is one cycle, with address=12'h205, we=1 and data=32'h12345678; response data=0, error=0.
REQ-034 No slave valid, TIMEOUT_CYCLES=16 -> o_rsp_valid follows 16 cycles of WAIT with error=1 and data=0; o_timeout_count=1.
REQ-035 i_api_busy held high 3 cycles after the handshake -> o_api_cs is delayed exactly 3 cycles; response is correct.
REQ-036 i_rsp_ready held low 10 cycles -> response stays stable, o_cmd_ready=0 throughout, a new command is accepted only after consumption; stray valid during RESP is ignored.
REQ-037 i_areset_n pulsed low while in WAIT -> all outputs reset immediately; the slave valid arriving after release produces no response.
